// File: rtl/keypad_pkg.sv
// Shared keypad constants, FSM states and the key-to-matrix map used by both
// the responder and any scanner-side decode table.
package keypad_pkg;

  localparam logic [3:0] COL_IDLE = 4'b1111;
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  localparam logic [3:0] C1 = 4'b0111;
  localparam logic [3:0] C2 = 4'b1011;
  localparam logic [3:0] C3 = 4'b1101;
  localparam logic [3:0] C4 = 4'b1110;

  localparam logic [3:0] R1 = 4'b0111;
  localparam logic [3:0] R2 = 4'b1011;
  localparam logic [3:0] R3 = 4'b1101;
  localparam logic [3:0] R4 = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAKE,
    ST_HOLD,
    ST_BREAK,
    ST_GAP
  } state_t;

  // Returns {col_code, row_code}, both active-low one-hot.
  function automatic logic [7:0] key_to_colrow(input logic [3:0] code);
    logic [7:0] cr;
    case (code)
      4'h1: cr = {C1, R1};
      4'h4: cr = {C1, R2};
      4'h7: cr = {C1, R3};
      4'h0: cr = {C1, R4};
      4'h2: cr = {C2, R1};
      4'h5: cr = {C2, R2};
      4'h8: cr = {C2, R3};
      4'hF: cr = {C2, R4};
      4'h3: cr = {C3, R1};
      4'h6: cr = {C3, R2};
      4'h9: cr = {C3, R3};
      4'hE: cr = {C3, R4};
      4'hA: cr = {C4, R1};
      4'hB: cr = {C4, R2};
      4'hC: cr = {C4, R3};
      default: cr = {C4, R4};
    endcase
    return cr;
  endfunction

endpackage

// File: rtl/keypad_bounce_gen.sv
// Pseudo-random contact-bounce source: 8-bit LFSR advanced once every STEP
// enabled cycles; the step counter restarts whenever the enable drops.
module keypad_bounce_gen #(
  parameter int STEP = 512
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bounce
);

  localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP - 1);

  logic [SW-1:0] step_cnt;
  logic [7:0]    lfsr;

  // x^8+x^6+x^5+x^4+1; a nonzero seed never reaches the all-zero lock-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      lfsr     <= 8'hA5;
    end else if (!en) begin
      step_cnt <= '0;
    end else if (step_cnt == STEP_LAST) begin
      step_cnt <= '0;
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  assign bounce = lfsr[0];

endmodule

// File: rtl/keypad_responder.sv
// Device-side 4x4 keypad emulator: accepts key presses over valid/ready and
// pulls the matching row low whenever the scanner strobes that key's column.
module keypad_responder
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 500000,
  parameter int BOUNCE_EN     = 1,
  parameter int BOUNCE_CYCLES = 20000,
  parameter int BOUNCE_STEP   = 512,
  parameter int GAP_CYCLES    = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       busy,
  output logic       contact
);

  localparam int MAX_HB = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int MAX_C  = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  // Counter reloads are duration-1 so each state lasts exactly its parameter.
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] BNC_LD  = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    key_col, key_row;
  logic [3:0]    col_s1, col_s2;
  logic          bounce, bounce_on;
  logic          xfer, tc;

  assign xfer      = key_valid && key_ready;
  assign tc        = (cnt == '0);
  assign bounce_on = (state == ST_MAKE) || (state == ST_BREAK);

  keypad_bounce_gen #(.STEP(BOUNCE_STEP)) u_bounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (bounce_on),
    .bounce (bounce)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key_col   <= COL_IDLE;
      key_row   <= ROW_IDLE;
      key_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          key_ready <= 1'b1;
          busy      <= 1'b0;
          if (xfer) begin
            {key_col, key_row} <= key_to_colrow(key_code);
            key_ready <= 1'b0;
            busy      <= 1'b1;
            if (BOUNCE_EN != 0) begin
              state <= ST_MAKE;
              cnt   <= BNC_LD;
            end else begin
              state <= ST_HOLD;
              cnt   <= HOLD_LD;
            end
          end
        end
        ST_MAKE: begin
          if (tc) begin
            state <= ST_HOLD;
            cnt   <= HOLD_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (tc) begin
            if (BOUNCE_EN != 0) begin
              state <= ST_BREAK;
              cnt   <= BNC_LD;
            end else begin
              state <= ST_GAP;
              cnt   <= GAP_LD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_BREAK: begin
          if (tc) begin
            state <= ST_GAP;
            cnt   <= GAP_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (tc) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          key_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    contact = 1'b0;
    case (state)
      ST_HOLD:           contact = 1'b1;
      ST_MAKE, ST_BREAK: contact = bounce;
      default:           contact = 1'b0;
    endcase
  end

  // key_col is one-hot-low, so equality also rejects idle and multi-low strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= COL_IDLE;
      col_s2 <= COL_IDLE;
      row    <= ROW_IDLE;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
      row    <= (contact && (col_s2 == key_col)) ? key_row : ROW_IDLE;
    end
  end

endmodule

// File: tb/tb_keypad_responder.sv
// Randomized scoreboard bench: a clean-edge and a bouncing responder run side
// by side against a press-waveform reference model.
module tb_keypad_responder;

  localparam int HOLD = 64;
  localparam int BNC  = 16;
  localparam int STEP = 2;
  localparam int GAP  = 8;

  typedef struct packed {
    logic [3:0] row;
    logic       rdy;
    logic       bsy;
    logic       cont;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col = 4'hF;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;

  int vectors = 0;
  int miscompares = 0;

  // Physical layout: keymap[column][row], column/row 0 is the leftmost/top line.
  logic [3:0] keymap [4][4] = '{'{4'h1, 4'h4, 4'h7, 4'h0},
                                '{4'h2, 4'h5, 4'h8, 4'hF},
                                '{4'h3, 4'h6, 4'h9, 4'hE},
                                '{4'hA, 4'hB, 4'hC, 4'hD}};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic map_key(input logic [3:0] k, output logic [3:0] c, output logic [3:0] r);
    c = 4'hF;
    r = 4'hF;
    for (int ci = 0; ci < 4; ci++)
      for (int ri = 0; ri < 4; ri++)
        if (keymap[ci][ri] == k) begin
          c = ~(4'b1000 >> ci);
          r = ~(4'b1000 >> ri);
        end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] row;
    logic       rdy, bsy, cont;

    keypad_responder #(
      .HOLD_CYCLES(HOLD), .BOUNCE_EN(g), .BOUNCE_CYCLES(BNC),
      .BOUNCE_STEP(STEP), .GAP_CYCLES(GAP)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .col(col), .row(row),
      .key_valid(key_valid), .key_code(key_code),
      .key_ready(rdy), .busy(bsy), .contact(cont)
    );

    // Reference: an accepted press expands into its whole contact waveform.
    obs_t       exp_q[$];
    bit         plan[$];
    logic [7:0] lfsr;
    logic [3:0] s1, s2, m_col, m_row;
    bit         c_prev, rdy_m;

    always @(posedge clk or negedge rst_n) begin
      obs_t e;
      if (!rst_n) begin
        plan.delete();
        exp_q.delete();
        lfsr = 8'hA5; s1 = 4'hF; s2 = 4'hF; m_col = 4'hF; m_row = 4'hF;
        c_prev = 1'b0; rdy_m = 1'b0;
      end else begin
        e.row = (c_prev && s2 == m_col) ? m_row : 4'hF;
        s2 = s1;
        s1 = col;
        if (plan.size() > 0) begin
          void'(plan.pop_front());
        end else if (key_valid && rdy_m) begin
          map_key(key_code, m_col, m_row);
          for (int w = 0; w < 4; w++) begin
            int len;
            bit bw;
            bw  = (w == 0 || w == 2);
            len = (w == 1) ? HOLD : (w == 3) ? GAP : BNC;
            if (!bw || g == 1)
              for (int i = 0; i < len; i++) begin
                if (bw) begin
                  plan.push_back(lfsr[0]);
                  if ((i + 1) % STEP == 0) lfsr = {lfsr[6:0], ^(lfsr & 8'b1011_1000)};
                end else begin
                  plan.push_back(w == 1);
                end
              end
          end
        end
        c_prev = (plan.size() > 0) ? plan[0] : 1'b0;
        rdy_m  = (plan.size() == 0);
        e.rdy  = rdy_m;
        e.bsy  = !rdy_m;
        e.cont = c_prev;
        exp_q.push_back(e);
      end
    end

    always @(negedge clk) begin
      obs_t e;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("u%0d.row", g), row, e.row);
        chk($sformatf("u%0d.key_ready", g), {3'b0, rdy}, {3'b0, e.rdy});
        chk($sformatf("u%0d.busy", g), {3'b0, bsy}, {3'b0, e.bsy});
        chk($sformatf("u%0d.contact", g), {3'b0, cont}, {3'b0, e.cont});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input int n);
    rst_n = 1'b0;
    #1;
    chk("rst.row0", g_dut[0].row, 4'hF);
    chk("rst.row1", g_dut[1].row, 4'hF);
    chk("rst.busy0", {3'b0, g_dut[0].bsy}, 4'h0);
    chk("rst.busy1", {3'b0, g_dut[1].bsy}, 4'h0);
    chk("rst.ready0", {3'b0, g_dut[0].rdy}, 4'h0);
    chk("rst.contact1", {3'b0, g_dut[1].cont}, 4'h0);
    tick(n);
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [3:0] k, input logic [3:0] c, input int wait_cycles);
    col = c;
    key_code = k;
    key_valid = 1'b1;
    tick(2);
    key_valid = 1'b0;
    key_code = ~k;
    tick(wait_cycles);
  endtask

  initial begin
    logic [3:0] kc, kr;
    tick(3);
    reset_pulse(2);
    tick(1);

    // Clean press of 5 under a steady column, then 9 under its column.
    press(4'h5, 4'b1011, 130);
    press(4'h9, 4'b1101, 130);

    // Key D with the scanner sweeping columns.
    press(4'hD, 4'b0111, 0);
    for (int i = 0; i < 14; i++) begin
      col = ~(4'b1000 >> (i % 4));
      tick(10);
    end

    // Back-to-back: valid held high, code switches from 1 to A after acceptance.
    key_code = 4'h1;
    key_valid = 1'b1;
    for (int i = 0; i < 26; i++) begin
      col = ~(4'b1000 >> (i % 4));
      if (i == 1) key_code = 4'hA;
      tick(10);
    end
    key_valid = 1'b0;
    tick(130);

    // Reset in the middle of HOLD for key 0.
    press(4'h0, 4'b0111, 40);
    reset_pulse(3);
    tick(5);

    // Illegal and idle strobes during HOLD of key 1.
    press(4'h1, 4'b0111, 30);
    col = 4'b0011; tick(10);
    col = 4'b1111; tick(10);
    col = 4'b0111; tick(80);

    // Randomized traffic with occasional resets.
    for (int it = 0; it < 2000; it++) begin
      int sel;
      key_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) key_code = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 7);
      map_key(key_code, kc, kr);
      case (sel)
        0, 1, 2, 3: col = ~(4'b1000 >> sel);
        4:          col = 4'hF;
        5:          col = 4'($urandom_range(0, 15));
        default:    col = kc;
      endcase
      if ($urandom_range(0, 299) == 0) reset_pulse($urandom_range(1, 3));
      tick($urandom_range(1, 12));
    end
    key_valid = 1'b0;
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
